// File: rtl/nr_polar_crc_attach.sv
// Bit-serial CRC24C attachment ahead of the NR polar encoder: forwards payload bits, appends 24 parity bits, reports K.
// Optional DCI mode via POLAR_CRC_RNTI_MASK_EN: all-ones CRC init and RNTI mask on the last 16 parity bits.
module nr_polar_crc_attach #(
  parameter int CRC_LEN = 24,
  parameter int MAX_A   = 999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enb,
  input  logic        dataIn,
  input  logic        ctrlIn_start,
  input  logic        ctrlIn_end,
  input  logic        ctrlIn_valid,
  input  logic [15:0] rnti,
  input  logic        nextFrame,
  output logic        ready,
  output logic        dataOut,
  output logic        ctrlOut_start,
  output logic        ctrlOut_end,
  output logic        ctrlOut_valid,
  output logic [9:0]  K,
  output logic        lenErr
);

  localparam logic [CRC_LEN-1:0] POLY = 24'hB2B117;
`ifdef POLAR_CRC_RNTI_MASK_EN
  localparam logic [CRC_LEN-1:0] CRC_INIT = 24'hFFFFFF;
`else
  localparam logic [CRC_LEN-1:0] CRC_INIT = 24'h000000;
`endif

  typedef enum logic [1:0] {IDLE, DATA, PARITY, FLUSH} state_t;

  state_t             state;
  logic [CRC_LEN-1:0] crc;
  logic [9:0]         a_cnt;
  logic [4:0]         p_cnt;

  logic               start_acc;
  logic               take;
  logic [9:0]         a_new;
  logic [CRC_LEN-1:0] crc_in;
  logic [CRC_LEN-1:0] crc_end;

  function automatic logic [CRC_LEN-1:0] crc_step(input logic [CRC_LEN-1:0] c, input logic d);
    return {c[CRC_LEN-2:0], 1'b0} ^ ({CRC_LEN{c[CRC_LEN-1] ^ d}} & POLY);
  endfunction

  assign ready     = (state == IDLE) && nextFrame;
  // A start inside DATA restarts the frame; in IDLE it needs the encoder's consent.
  assign start_acc = ctrlIn_valid && ctrlIn_start && (ready || state == DATA);
  assign take      = ctrlIn_valid && (start_acc || state == DATA);
  assign a_new     = start_acc ? 10'd1 : ((a_cnt == 10'd1023) ? a_cnt : a_cnt + 10'd1);
  assign crc_in    = crc_step(start_acc ? CRC_INIT : crc, dataIn);

`ifdef POLAR_CRC_RNTI_MASK_EN
  logic [15:0] rnti_hold;
  // Folding the mask into the register at end lets the parity shifter stay mask-agnostic.
  assign crc_end = crc_in ^ {8'h00, (start_acc ? rnti : rnti_hold)};
`else
  logic unused_rnti;
  assign unused_rnti = ^rnti;
  assign crc_end     = crc_in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      crc           <= '0;
      a_cnt         <= '0;
      p_cnt         <= '0;
      K             <= '0;
      dataOut       <= 1'b0;
      ctrlOut_start <= 1'b0;
      ctrlOut_end   <= 1'b0;
      ctrlOut_valid <= 1'b0;
      lenErr        <= 1'b0;
`ifdef POLAR_CRC_RNTI_MASK_EN
      rnti_hold     <= '0;
`endif
    end else if (enb) begin
      dataOut       <= 1'b0;
      ctrlOut_start <= 1'b0;
      ctrlOut_end   <= 1'b0;
      ctrlOut_valid <= 1'b0;
      lenErr        <= 1'b0;
      case (state)
        IDLE, DATA: begin
          if (take) begin
            dataOut       <= dataIn;
            ctrlOut_valid <= 1'b1;
            ctrlOut_start <= start_acc;
            a_cnt         <= a_new;
`ifdef POLAR_CRC_RNTI_MASK_EN
            if (start_acc) rnti_hold <= rnti;
`endif
            if (ctrlIn_end) begin
              crc    <= crc_end;
              p_cnt  <= '0;
              lenErr <= (a_new > 10'(MAX_A));
              state  <= PARITY;
            end else begin
              crc   <= crc_in;
              state <= DATA;
            end
          end
        end
        PARITY: begin
          dataOut       <= crc[CRC_LEN-1];
          ctrlOut_valid <= 1'b1;
          crc           <= {crc[CRC_LEN-2:0], 1'b0};
          p_cnt         <= p_cnt + 5'd1;
          if (p_cnt == 5'(CRC_LEN - 1)) begin
            ctrlOut_end <= 1'b1;
            K           <= (a_cnt > 10'(MAX_A)) ? 10'd1023 : a_cnt + 10'(CRC_LEN);
            state       <= FLUSH;
          end
        end
        // One settling cycle keeps ready low while the final parity bit is on the output.
        FLUSH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
